hilo_muldiv_unit: RTL

- Parametrised iterative multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle HI/LO path in Execute, which has fixed width and no stall. Adds divide, configurable width and throughput, abort on flush, and a stall request.
- Sits beside the EX stage. Its Stall output feeds the hazard detection unit; its Hi/Lo outputs feed the MEM-stage HI/LO select.

---
 rtl/hilo_muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Shift-add multiply and restoring divide, STEPS_PER_CYCLE steps per clock, abortable by Flush.
module hilo_muldiv_unit #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    input  logic                  Flush,
    input  logic                  HiLoRead,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned N     = DATA_WIDTH / STEPS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

    stateT            state, stateNext;
    logic [2:0]       opQ;
    logic [W-1:0]     opnd;     // multiplicand magnitude, or divisor magnitude
    logic [W-1:0]     low;      // multiplier / product low half, or dividend / quotient
    logic [W-1:0]     acc;      // product high half, or partial remainder
    logic [W-1:0]     rawA;
    logic             negRes, negRem;
    logic [CNT_W-1:0] cnt;

    logic             signedOp, divOp, aNeg, bNeg;
    logic [W-1:0]     aMag, bMag;
    logic [W-1:0]     accStep, lowStep;
    logic [W:0]       sum, rem;
    logic [2*W-1:0]   product, signedProd;
    logic [W-1:0]     fixHi, fixLo;

    assign Busy  = (state != IDLE);
    assign Stall = Busy & (HiLoRead | Start);

    // Operand conditioning at acceptance: MULT, DIV, MADD, MSUB are signed
    assign signedOp = ~Op[0] | Op[2];
    assign divOp    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign aNeg     = signedOp & OperandA[W-1];
    assign bNeg     = signedOp & OperandB[W-1];
    assign aMag     = aNeg ? -OperandA : OperandA;
    assign bMag     = bNeg ? -OperandB : OperandB;

    // STEPS_PER_CYCLE iterations of shift-add or restoring divide
    always_comb begin
        accStep = acc;
        lowStep = low;
        sum     = '0;
        rem     = '0;
        for (int s = 0; s < int'(STEPS_PER_CYCLE); s++) begin
            if ((opQ == OP_DIV) || (opQ == OP_DIVU)) begin
                rem     = {accStep, lowStep[W-1]};
                lowStep = {lowStep[W-2:0], 1'b0};
                if (rem >= {1'b0, opnd}) begin
                    rem        = rem - {1'b0, opnd};
                    lowStep[0] = 1'b1;
                end
                accStep = rem[W-1:0];
            end else begin
                sum     = {1'b0, accStep} + (lowStep[0] ? {1'b0, opnd} : '0);
                lowStep = {sum[0], lowStep[W-1:1]};
                accStep = sum[W:1];
            end
        end
    end

    // Sign fix-up and HI/LO result selection
    always_comb begin
        product    = {acc, low};
        signedProd = negRes ? -product : product;
        fixHi      = Hi;
        fixLo      = Lo;
        case (opQ)
            OP_MULT, OP_MULTU: {fixHi, fixLo} = signedProd;
            OP_MADD:           {fixHi, fixLo} = {Hi, Lo} + signedProd;
            OP_MSUB:           {fixHi, fixLo} = {Hi, Lo} - signedProd;
            OP_DIV, OP_DIVU: begin
                if (opnd == '0) begin
                    fixHi = rawA;
                    fixLo = '1;
                end else begin
                    fixLo = negRes ? -low : low;
                    fixHi = negRem ? -acc : acc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (Start && !Flush && (Op <= OP_MSUB)) stateNext = CALC;
            CALC: begin
                if (Flush)                           stateNext = IDLE;
                else if (cnt == CNT_W'(N - 1))      stateNext = FIX;
            end
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Hi     <= '0;
            Lo     <= '0;
            Done   <= 1'b0;
            opQ    <= OP_MULT;
            opnd   <= '0;
            low    <= '0;
            acc    <= '0;
            rawA   <= '0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            cnt    <= '0;
        end else begin
            Done <= (state == FIX) && !Flush;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (Op == OP_MTHI) begin
                            Hi <= OperandA;
                        end else if (Op == OP_MTLO) begin
                            Lo <= OperandA;
                        end else begin
                            opQ    <= Op;
                            opnd   <= divOp ? bMag : aMag;
                            low    <= divOp ? aMag : bMag;
                            acc    <= '0;
                            rawA   <= OperandA;
                            negRes <= aNeg ^ bNeg;
                            negRem <= aNeg;
                            cnt    <= '0;
                        end
                    end
                end
                CALC: begin
                    acc <= accStep;
                    low <= lowStep;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (!Flush) begin
                        Hi <= fixHi;
                        Lo <= fixLo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
